fifo_enq_arbiter: RTL

- Shares one FIFO queue write port among NUM_REQ producers using round-robin arbitration with bounded bursts.
- Tracks FIFO occupancy with a credit counter, so it never issues an enqueue into a full queue and does not rely on the FIFO's lagging full flag.
- Sits directly in front of the FIFO queue: it drives its enq/din and observes the consumer's accepted dequeues.

---
 rtl/fifo_arb_pkg.sv | 35 +++
 rtl/fifo_enq_arbiter_rr_priority_pick.sv | 22 ++
 rtl/fifo_enq_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO enqueue arbiter: FSM states, the
// round-robin pick function and default width constants.
package fifo_arb_pkg;

  localparam int MAX_REQ     = 16;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DEPTH   = 16;
  localparam int OWN_W       = $clog2(DEF_NUM_REQ);
  localparam int CRED_W      = $clog2(DEF_DEPTH + 1);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First set bit of req at or above ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [3:0] ptr, input int n);
    pick_t r;
    int    j;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !r.found && req[4'(j)]) begin
        r.found = 1'b1;
        r.idx   = 4'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_enq_arbiter_rr_priority_pick.sv
// Combinational rotate-and-find-first selector used when no burst is active.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   ptr,
  output logic [OWN_W-1:0]   idx,
  output logic               found
);

  pick_t p;

  always_comb begin
    p     = rr_pick(MAX_REQ'(req), 4'(ptr), NUM_REQ);
    idx   = OWN_W'(p.idx);
    found = p.found;
  end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among
// NUM_REQ producers, with a local credit count of free FIFO slots.
module fifo_enq_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          deq_done,
  output logic                          fifo_enq,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic [$clog2(DEPTH+1)-1:0]    credits,
  output logic                          err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  state_t          state, state_n;
  logic [OW-1:0]   rr_ptr, rr_ptr_n, owner_n, pick_idx;
  logic [BW-1:0]   beat_cnt, beat_n;
  logic [CW-1:0]   credits_n;
  logic            pick_found, can_grant, gnt_any, ret;

  function automatic logic [OW-1:0] nxt(input logic [OW-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
  endfunction

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .OWN_W(OW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign can_grant = (credits != '0);

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    owner_n  = owner;
    beat_n   = beat_cnt;
    gnt      = '0;
    if (!rst) begin
      case (state)
        IDLE: if (can_grant && pick_found) begin
          gnt[pick_idx] = 1'b1;
          owner_n       = pick_idx;
          beat_n        = BW'(1);
          if (MAX_BURST == 1) rr_ptr_n = nxt(pick_idx);
          else                state_n  = BURST;
        end
        BURST: if (!req[owner]) begin
          // Owner released early: hand the scan to the next producer.
          state_n  = IDLE;
          rr_ptr_n = nxt(owner);
        end else if (can_grant) begin
          gnt[owner] = 1'b1;
          beat_n     = beat_cnt + 1'b1;
          if (int'(beat_cnt) + 1 >= MAX_BURST) begin
            state_n  = IDLE;
            rr_ptr_n = nxt(owner);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign gnt_any   = |gnt;
  assign ret       = deq_done && (credits != CW'(DEPTH));
  assign credits_n = credits - CW'(gnt_any) + CW'(ret);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      credits  <= CW'(DEPTH);
      fifo_enq <= 1'b0;
      fifo_din <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      beat_cnt <= beat_n;
      credits  <= credits_n;
      fifo_enq <= gnt_any;
      if (gnt_any) fifo_din <= req_data[owner_n*DATA_WIDTH +: DATA_WIDTH];
      if (deq_done && credits == CW'(DEPTH)) err <= 1'b1;
    end
  end

  a_gnt_safe: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt) && !(gnt_any && credits == '0));

endmodule
